multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Main control FSM for the multi-cycle MIPS core. Sequences the shared ALU, register file, PC, IR and unified memory.
//  Emits alu_ct_op to the ALU control decoder, which combines it with funct to form alu_ct.
//  Stalls on a memory ready handshake and aborts any access that exceeds a timeout.
// PARAMETERS
//  MEM_TIMEOUT  15  max cycles waiting for mem_ready before abort (1..255)
// PORTS
//  clk          in   1  system clock, all state on rising edge
//  rst          in   1  asynchronous, active-high reset
//  opcode       in   6  IR[31:26], valid from DECODE onward
//  zero         in   1  ALU zero flag
//  mem_ready    in   1  memory completes current read/write this cycle
//  pc_write     out  1  unconditional PC load
//  pc_write_cond out 1  PC load if zero (beq)
//  iord         out  1  0: memory addr = PC, 1: addr = ALUOut
//  mem_read     out  1  memory read request, held until mem_ready
//  mem_write    out  1  memory write request, held until mem_ready
//  ir_write     out  1  IR load
//  reg_dst      out  1  0: rt, 1: rd
//  mem_to_reg   out  1  0: ALUOut, 1: MDR
//  reg_write    out  1  register file write enable
//  alu_src_a    out  1  0: PC, 1: rs
//  alu_src_b    out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  alu_ct_op    out  2  00 add, 01 sub, 10 use funct
//  pc_source    out  2  00 ALU, 01 ALUOut, 10 jump target
//  illegal_op   out  1  1-cycle pulse on unsupported opcode
//  bus_err      out  1  1-cycle pulse on memory timeout
// BEHAVIOUR
//  Moore FSM; all outputs decode from the state register except the two gated strobes noted below.
//  Reset (async, rst=1): state=IDLE, wait counter=0, every output 0.
//  IDLE: all outputs 0; next cycle -> FETCH.
//  FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_ct_op=00, pc_source=00.
//   - ir_write and pc_write equal mem_ready; they are never asserted without it.
//   - mem_ready=1 -> DECODE; otherwise stay.
//  DECODE: alu_src_a=0, alu_src_b=11, alu_ct_op=00 (branch target into ALUOut). Dispatch on opcode:
//   - 000000 -> EXEC_R
//   - 100011 lw / 101011 sw -> MEM_ADDR
//   - 001001 addiu -> EXEC_I
//   - 000100 beq -> BRANCH
//   - 000010 j -> JUMP
//   - other: pulse illegal_op -> FETCH (PC already advanced)
//  MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_ct_op=00; lw -> MEM_RD, sw -> MEM_WR.
//  MEM_RD: iord=1, mem_read=1; stay until mem_ready -> MEM_WB.
//  MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH.
//  MEM_WR: iord=1, mem_write=1; stay until mem_ready -> FETCH.
//  EXEC_R: alu_src_a=1, alu_src_b=00, alu_ct_op=10 -> R_WB.
//  R_WB: reg_dst=1, mem_to_reg=0, reg_write=1 -> FETCH.
//  EXEC_I: alu_src_a=1, alu_src_b=10, alu_ct_op=00 -> I_WB.
//  I_WB: reg_dst=0, mem_to_reg=0, reg_write=1 -> FETCH.
//  BRANCH: alu_src_a=1, alu_src_b=00, alu_ct_op=01, pc_source=01, pc_write_cond=1 -> FETCH.
//  JUMP: pc_source=10, pc_write=1 -> FETCH.
//  Latencies: R/addiu/beq/j 3-4 cycles; lw 5 and sw 4, each plus memory wait cycles.
//  Timeout counter (8 bit):
//   - clears on entry to any waiting state (FETCH/MEM_RD/MEM_WR).
//   - increments each waiting cycle with mem_ready=0.
//   - on the MEM_TIMEOUT-th miss: drop request, pulse bus_err, go FETCH, no IR/PC/regfile/mem write.
//   - mem_ready on the same cycle as the timeout wins: normal completion, no bus_err.
//  mem_ready outside a waiting state is ignored.
//  opcode is sampled only in DECODE, and in MEM_ADDR for the lw/sw split.
//  Reset mid-access drops the request immediately (async); no partial write is signalled.
// STRUCTURE
//  Shared package mips_ctrl_pkg:
//   - state localparams (4-bit encoding)
//   - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDIU)
//   - ALU_OP_ADD/SUB/FUNCT, shared with the ALU control decoder
//  No sub-module; the timeout counter is inline.
// TESTING
//  1. Reset, then release with mem_ready=1 -> IDLE 1 cycle; FETCH asserts ir_write=pc_write=1, next state DECODE.
//  2. R-type (000000), mem_ready=1 -> alu_ct_op=10 in EXEC_R; reg_write=1, reg_dst=1 in R_WB; 4 cycles FETCH to FETCH.
//  3. lw with mem_ready low 3 cycles in MEM_RD -> mem_read, iord held 4 cycles; MEM_WB reg_write=1, mem_to_reg=1.
//  4. beq with zero=1 vs zero=0 -> pc_write_cond=1 and alu_ct_op=01 in BRANCH both times; return to FETCH.
//  5. opcode 111111 -> illegal_op pulses 1 cycle, no reg_write/mem_write, next state FETCH.
//  6. sw, mem_ready never asserted -> bus_err after 15 wait cycles, mem_write drops; rst during MEM_WR -> all outputs 0 immediately.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_ctrl_pkg
//  Description : Shared definitions for the multi-cycle MIPS control path:
//                FSM state encoding, opcode constants, ALU operation codes
//                (shared with the ALU control decoder) and the per-state
//                control-word decode used by multicycle_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    // ------------------------------------------------------------------
    // FSM state encoding (4 bit)
    // ------------------------------------------------------------------
    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE     = 4'd0;
    localparam state_t ST_FETCH    = 4'd1;
    localparam state_t ST_DECODE   = 4'd2;
    localparam state_t ST_MEM_ADDR = 4'd3;
    localparam state_t ST_MEM_RD   = 4'd4;
    localparam state_t ST_MEM_WB   = 4'd5;
    localparam state_t ST_MEM_WR   = 4'd6;
    localparam state_t ST_EXEC_R   = 4'd7;
    localparam state_t ST_R_WB     = 4'd8;
    localparam state_t ST_EXEC_I   = 4'd9;
    localparam state_t ST_I_WB     = 4'd10;
    localparam state_t ST_BRANCH   = 4'd11;
    localparam state_t ST_JUMP     = 4'd12;

    // ------------------------------------------------------------------
    // Opcodes (IR[31:26])
    // ------------------------------------------------------------------
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDIU = 6'b001001;

    // ------------------------------------------------------------------
    // ALU operation requests to the ALU control decoder
    // ------------------------------------------------------------------
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // ALU B-operand and PC source selects
    localparam logic [1:0] SRC_B_RT      = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // ------------------------------------------------------------------
    // Moore control word. ir_write and the fetch-time pc_write are not
    // part of it: they are gated by mem_ready in the top level.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_ct_op;
        logic [1:0] pc_source;
    } ctl_t;

    function automatic ctl_t ctl_decode(input state_t st);
        ctl_t c;
        c = '0;
        case (st)
            ST_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRC_B_FOUR;
                c.alu_ct_op = ALU_OP_ADD;
                c.pc_source = PC_SRC_ALU;
            end
            ST_DECODE: begin
                c.alu_src_b = SRC_B_IMM_SH2;
                c.alu_ct_op = ALU_OP_ADD;
            end
            ST_MEM_ADDR, ST_EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_IMM;
                c.alu_ct_op = ALU_OP_ADD;
            end
            ST_MEM_RD: begin
                c.iord     = 1'b1;
                c.mem_read = 1'b1;
            end
            ST_MEM_WB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            ST_MEM_WR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            ST_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_RT;
                c.alu_ct_op = ALU_OP_FUNCT;
            end
            ST_R_WB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            ST_I_WB: begin
                c.reg_write = 1'b1;
            end
            ST_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRC_B_RT;
                c.alu_ct_op     = ALU_OP_SUB;
                c.pc_source     = PC_SRC_ALUOUT;
                c.pc_write_cond = 1'b1;
            end
            ST_JUMP: begin
                c.pc_source = PC_SRC_JUMP;
                c.pc_write  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // States that hold a memory request open until mem_ready
    function automatic logic is_wait_state(input state_t st);
        return (st == ST_FETCH) || (st == ST_MEM_RD) || (st == ST_MEM_WR);
    endfunction

endpackage : mips_ctrl_pkg
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Main control FSM of the multi-cycle MIPS core. Sequences the
//                shared ALU, register file, PC, IR and unified memory; stalls
//                on mem_ready and aborts any access that waits MEM_TIMEOUT
//                cycles without completion (bus_err).
//  Ports       : clk, rst (async, active high)
//                opcode[5:0], zero, mem_ready            - inputs
//                pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
//                reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b[1:0],
//                alu_ct_op[1:0], pc_source[1:0], illegal_op, bus_err - outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15    // 1..255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_ct_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic       bus_err
);

    // Wait-counter value at which the next miss is the MEM_TIMEOUT-th one
    localparam logic [7:0] c_wait_last = 8'(MEM_TIMEOUT - 1);

    state_t     r_state;
    state_t     w_state_next;
    ctl_t       r_ctl;
    logic [7:0] r_wait_cnt;
    logic       r_illegal;
    logic       r_bus_err;
    logic       w_timeout;
    logic       w_illegal;
    logic       w_in_fetch;

    // zero is consumed by the datapath's branch gating, not by the sequencer
    logic       w_unused_zero;
    assign w_unused_zero = zero;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_illegal    = 1'b0;
        w_timeout    = is_wait_state(r_state) && !mem_ready &&
                       (r_wait_cnt == c_wait_last);
        case (r_state)
            ST_IDLE:   w_state_next = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready)      w_state_next = ST_DECODE;
                else if (w_timeout) w_state_next = ST_FETCH;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:     w_state_next = ST_EXEC_R;
                    OP_LW, OP_SW: w_state_next = ST_MEM_ADDR;
                    OP_ADDIU:     w_state_next = ST_EXEC_I;
                    OP_BEQ:       w_state_next = ST_BRANCH;
                    OP_J:         w_state_next = ST_JUMP;
                    default: begin
                        // PC was already advanced in FETCH; just refetch
                        w_state_next = ST_FETCH;
                        w_illegal    = 1'b1;
                    end
                endcase
            end
            ST_MEM_ADDR: w_state_next = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD: begin
                if (mem_ready)      w_state_next = ST_MEM_WB;
                else if (w_timeout) w_state_next = ST_FETCH;
            end
            ST_MEM_WR: begin
                if (mem_ready || w_timeout) w_state_next = ST_FETCH;
            end
            ST_EXEC_R: w_state_next = ST_R_WB;
            ST_EXEC_I: w_state_next = ST_I_WB;
            ST_MEM_WB, ST_R_WB, ST_I_WB, ST_BRANCH, ST_JUMP:
                       w_state_next = ST_FETCH;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, control word, wait counter and event pulses. The control word
    // is decoded from the next state so outputs come straight from flops.
    // The pulses are visible during the cycle after the event (first FETCH).
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ctl      <= '0;
            r_wait_cnt <= 8'd0;
            r_illegal  <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_ctl     <= ctl_decode(w_state_next);
            r_illegal <= w_illegal;
            r_bus_err <= w_timeout;
            // A timed-out fetch re-enters FETCH, which counts as a new entry
            if (is_wait_state(w_state_next) &&
                ((w_state_next != r_state) || w_timeout)) begin
                r_wait_cnt <= 8'd0;
            end else if (is_wait_state(r_state) && !mem_ready) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. IR load and PC increment happen only on a completed fetch.
    // ------------------------------------------------------------------
    assign w_in_fetch    = (r_state == ST_FETCH);
    assign ir_write      = w_in_fetch && mem_ready;
    assign pc_write      = r_ctl.pc_write || (w_in_fetch && mem_ready);
    assign pc_write_cond = r_ctl.pc_write_cond;
    assign iord          = r_ctl.iord;
    assign mem_read      = r_ctl.mem_read;
    assign mem_write     = r_ctl.mem_write;
    assign reg_dst       = r_ctl.reg_dst;
    assign mem_to_reg    = r_ctl.mem_to_reg;
    assign reg_write     = r_ctl.reg_write;
    assign alu_src_a     = r_ctl.alu_src_a;
    assign alu_src_b     = r_ctl.alu_src_b;
    assign alu_ct_op     = r_ctl.alu_ct_op;
    assign pc_source     = r_ctl.pc_source;
    assign illegal_op    = r_illegal;
    assign bus_err       = r_bus_err;

endmodule : multicycle_ctrl
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Self-checking bench for multicycle_ctrl. An instruction-level
//                model expands each instruction (class, fetch wait, memory
//                wait) into the expected per-cycle control outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    localparam int         TO       = 15;
    localparam logic [5:0] K_RTYPE  = 6'b000000;
    localparam logic [5:0] K_LW     = 6'b100011;
    localparam logic [5:0] K_SW     = 6'b101011;
    localparam logic [5:0] K_BEQ    = 6'b000100;
    localparam logic [5:0] K_J      = 6'b000010;
    localparam logic [5:0] K_ADDIU  = 6'b001001;
    localparam logic [5:0] K_BAD    = 6'b111111;

    typedef struct packed {
        logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
        logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_ct_op, pc_source;
        logic       illegal_op, bus_err;
    } obs_t;

    typedef struct packed {
        logic       rdy;
        logic [5:0] op;
        logic       z;
    } stim_t;

    logic       clk, rst, zero, mem_ready;
    logic [5:0] opcode;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op, bus_err;
    logic [1:0] alu_src_b, alu_ct_op, pc_source;
    obs_t       w_obs;

    int n_checks = 0;
    int n_errors = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ct_op(alu_ct_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .bus_err(bus_err)
    );

    assign w_obs = '{pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                     reg_dst, mem_to_reg, reg_write, alu_src_a,
                     alu_src_b, alu_ct_op, pc_source, illegal_op, bus_err};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Reference model: expected outputs of each named phase of the
    // instruction sequence, plus event pulses carried to the next fetch.
    // ------------------------------------------------------------------
    obs_t  eq[$];
    stim_t sq[$];
    string nq[$];
    bit    m_pend_ill = 1'b0;
    bit    m_pend_bus = 1'b0;
    bit    m_first;

    function automatic obs_t exp_of(input string ph, input bit rdy);
        obs_t e = '0;
        case (ph)
            "FETCH":    begin e.mem_read = 1; e.alu_src_b = 2'b01;
                              e.ir_write = rdy; e.pc_write = rdy; end
            "DECODE":   e.alu_src_b = 2'b11;
            "MEM_ADDR", "EXEC_I":
                        begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            "MEM_RD":   begin e.iord = 1; e.mem_read = 1; end
            "MEM_WB":   begin e.mem_to_reg = 1; e.reg_write = 1; end
            "MEM_WR":   begin e.iord = 1; e.mem_write = 1; end
            "EXEC_R":   begin e.alu_src_a = 1; e.alu_ct_op = 2'b10; end
            "R_WB":     begin e.reg_dst = 1; e.reg_write = 1; end
            "I_WB":     e.reg_write = 1;
            "BRANCH":   begin e.alu_src_a = 1; e.alu_ct_op = 2'b01;
                              e.pc_source = 2'b01; e.pc_write_cond = 1; end
            "JUMP":     begin e.pc_source = 2'b10; e.pc_write = 1; end
            default:    e = '0;
        endcase
        return e;
    endfunction

    function automatic logic [5:0] rnd_op();
        logic [5:0] v = 6'($urandom());
        return v;
    endfunction

    task automatic push(input string ph, input bit rdy, input logic [5:0] op, input bit z);
        obs_t e = exp_of(ph, rdy);
        if (m_first) begin
            e.illegal_op = m_pend_ill;
            e.bus_err    = m_pend_bus;
            m_pend_ill   = 1'b0;
            m_pend_bus   = 1'b0;
            m_first      = 1'b0;
        end
        eq.push_back(e);
        sq.push_back('{rdy, op, z});
        nq.push_back(ph);
    endtask

    // Expand one instruction, starting at its fetch, into stimulus/expected.
    // Opcode is only meaningful in DECODE and MEM_ADDR; elsewhere it is noise.
    task automatic build(input logic [5:0] op, input int fwait, input int mwait, input bit z);
        string ph;
        eq.delete(); sq.delete(); nq.delete();
        m_first = 1'b1;
        for (int i = 0; i < fwait; i++) push("FETCH", 1'b0, rnd_op(), z);
        push("FETCH", 1'b1, rnd_op(), z);
        push("DECODE", 1'($urandom()), op, z);
        if (op == K_RTYPE) begin
            push("EXEC_R", 1'($urandom()), rnd_op(), z);
            push("R_WB",   1'($urandom()), rnd_op(), z);
        end else if (op == K_LW || op == K_SW) begin
            push("MEM_ADDR", 1'($urandom()), op, z);
            ph = (op == K_LW) ? "MEM_RD" : "MEM_WR";
            if (mwait >= TO) begin
                for (int i = 0; i < TO; i++) push(ph, 1'b0, rnd_op(), z);
                m_pend_bus = 1'b1;
            end else begin
                for (int i = 0; i < mwait; i++) push(ph, 1'b0, rnd_op(), z);
                push(ph, 1'b1, rnd_op(), z);
                if (op == K_LW) push("MEM_WB", 1'($urandom()), rnd_op(), z);
            end
        end else if (op == K_ADDIU) begin
            push("EXEC_I", 1'($urandom()), rnd_op(), z);
            push("I_WB",   1'($urandom()), rnd_op(), z);
        end else if (op == K_BEQ) begin
            push("BRANCH", 1'($urandom()), rnd_op(), z);
        end else if (op == K_J) begin
            push("JUMP", 1'($urandom()), rnd_op(), z);
        end else begin
            m_pend_ill = 1'b1;
        end
    endtask

    // One clock: drive just after the rising edge, sample at the falling edge
    task automatic cycle(input stim_t s, output obs_t o);
        mem_ready = s.rdy;
        opcode    = s.op;
        zero      = s.z;
        @(negedge clk);
        o = w_obs;
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        obs_t o;
        rst = 1'b1; mem_ready = 1'b1; opcode = K_RTYPE; zero = 1'b0;
        #2;
        n_checks++;
        if (w_obs !== obs_t'(0)) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h expected %h", w_obs, obs_t'(0));
        end
        @(posedge clk); #1;
        rst = 1'b0;
        cycle('{1'b1, K_RTYPE, 1'b0}, o);
        n_checks++;
        if (o !== obs_t'(0)) begin
            n_errors++;
            $display("FAIL idle_after_reset: got %h expected %h", o, obs_t'(0));
        end
        build(K_RTYPE, 0, 0, 1'b0);
        for (int i = 0; i < eq.size(); i++) begin
            cycle(sq[i], o);
            n_checks++;
            if (o !== eq[i]) begin
                n_errors++;
                $display("FAIL reset_first_%s step %0d: got %h expected %h", nq[i], i, o, eq[i]);
            end
        end
    endtask

    task automatic test_rtype();
        obs_t o;
        build(K_RTYPE, 2, 0, 1'b1);
        for (int i = 0; i < eq.size(); i++) begin
            cycle(sq[i], o);
            n_checks++;
            if (o !== eq[i]) begin
                n_errors++;
                $display("FAIL rtype_%s step %0d: got %h expected %h", nq[i], i, o, eq[i]);
            end
        end
    endtask

    task automatic test_lw_wait();
        obs_t o;
        build(K_LW, 1, 3, 1'b0);
        for (int i = 0; i < eq.size(); i++) begin
            cycle(sq[i], o);
            n_checks++;
            if (o !== eq[i]) begin
                n_errors++;
                $display("FAIL lw_%s step %0d: got %h expected %h", nq[i], i, o, eq[i]);
            end
        end
        // ready arriving on the 15th wait cycle still completes normally
        build(K_LW, 0, TO - 1, 1'b0);
        for (int i = 0; i < eq.size(); i++) begin
            cycle(sq[i], o);
            n_checks++;
            if (o !== eq[i]) begin
                n_errors++;
                $display("FAIL lw_edge_%s step %0d: got %h expected %h", nq[i], i, o, eq[i]);
            end
        end
    endtask

    task automatic test_beq();
        obs_t o;
        for (int zz = 0; zz < 2; zz++) begin
            build(K_BEQ, 0, 0, zz[0]);
            for (int i = 0; i < eq.size(); i++) begin
                cycle(sq[i], o);
                n_checks++;
                if (o !== eq[i]) begin
                    n_errors++;
                    $display("FAIL beq_z%0d_%s step %0d: got %h expected %h", zz, nq[i], i, o, eq[i]);
                end
            end
        end
    endtask

    task automatic test_illegal();
        obs_t o;
        build(K_BAD, 0, 0, 1'b0);
        for (int i = 0; i < eq.size(); i++) begin
            cycle(sq[i], o);
            n_checks++;
            if (o !== eq[i]) begin
                n_errors++;
                $display("FAIL illegal_%s step %0d: got %h expected %h", nq[i], i, o, eq[i]);
            end
        end
        // the pulse shows in the following fetch
        build(K_J, 1, 0, 1'b0);
        for (int i = 0; i < eq.size(); i++) begin
            cycle(sq[i], o);
            n_checks++;
            if (o !== eq[i]) begin
                n_errors++;
                $display("FAIL after_illegal_%s step %0d: got %h expected %h", nq[i], i, o, eq[i]);
            end
        end
    endtask

    task automatic test_sw_timeout();
        obs_t o;
        build(K_SW, 0, 1000, 1'b0);
        for (int i = 0; i < eq.size(); i++) begin
            cycle(sq[i], o);
            n_checks++;
            if (o !== eq[i]) begin
                n_errors++;
                $display("FAIL sw_to_%s step %0d: got %h expected %h", nq[i], i, o, eq[i]);
            end
        end
        build(K_ADDIU, 0, 0, 1'b0);
        for (int i = 0; i < eq.size(); i++) begin
            cycle(sq[i], o);
            n_checks++;
            if (o !== eq[i]) begin
                n_errors++;
                $display("FAIL after_to_%s step %0d: got %h expected %h", nq[i], i, o, eq[i]);
            end
        end
        // reset in the middle of a store: everything drops at once
        build(K_SW, 0, 1000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(sq[i], o);
            n_checks++;
            if (o !== eq[i]) begin
                n_errors++;
                $display("FAIL sw_pre_rst_%s step %0d: got %h expected %h", nq[i], i, o, eq[i]);
            end
        end
        mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (w_obs !== obs_t'(0)) begin
            n_errors++;
            $display("FAIL rst_mid_write: got %h expected %h", w_obs, obs_t'(0));
        end
        @(posedge clk); #1;
        rst = 1'b0;
        m_pend_ill = 1'b0;
        m_pend_bus = 1'b0;
        cycle('{1'b1, K_SW, 1'b0}, o);
        n_checks++;
        if (o !== obs_t'(0)) begin
            n_errors++;
            $display("FAIL idle_after_mid_rst: got %h expected %h", o, obs_t'(0));
        end
    endtask

    task automatic test_back_to_back();
        obs_t       o;
        logic [5:0] ops[7];
        logic [5:0] op;
        ops = '{K_RTYPE, K_LW, K_SW, K_ADDIU, K_BEQ, K_J, K_BAD};
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) op = rnd_op();
            else                           op = ops[$urandom_range(0, 6)];
            build(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 16)), 1'($urandom()));
            for (int i = 0; i < eq.size(); i++) begin
                cycle(sq[i], o);
                n_checks++;
                if (o !== eq[i]) begin
                    n_errors++;
                    $display("FAIL rand%0d_op%b_%s step %0d: got %h expected %h",
                             n, op, nq[i], i, o, eq[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_beq();
        test_illegal();
        test_sw_timeout();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_multicycle_ctrl
`default_nettype wire
